contador_bcd: RTL and testbench

- Four-digit BCD event counter feeding the seven-segment display scanner.
- Generates its own count rate from a prescaler and accepts a manual step button.
- Presents four packed BCD digits plus update and overflow strobes.
- The display stage consumes `bcd` directly; `upd` and `ovf` are available for status pins.

---
 rtl/contador_bcd.sv | 135 +++++++++++++
 tb/tb_contador_bcd.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/contador_bcd.sv
// Four-digit BCD event counter with a free-running prescaler and a synchronised step button.
// Optional down counting is enabled by defining CONTADOR_BCD_DOWN_EN.
module contador_bcd #(
  parameter int PRESCALE = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        step,
  input  logic        dir,
  output logic [15:0] bcd,
  output logic        upd,
  output logic        ovf,
  output logic        tick
);

  localparam int              PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          s_meta_q, s_sync_q, s_prev_q, step_p_q;
  logic [15:0]   bcd_q, bcd_d;
  logic          upd_q, upd_d;
  logic          ovf_q, ovf_d;
  logic          ev;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef CONTADOR_BCD_DOWN_EN
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction
`else
  logic unused_dir;
  assign unused_dir = dir;
`endif

  // clr resets the prescaler and also keeps tick from firing while held
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      if (presc_q == PMAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign ev = tick_q | step_p_q;

  always_comb begin
    bcd_d = bcd_q;
    upd_d = 1'b0;
    ovf_d = 1'b0;
    if (clr) begin
      bcd_d = '0;
      upd_d = |bcd_q;
    end else if (ev) begin
      upd_d = 1'b1;
      bcd_d = bcd_inc(bcd_q);
      ovf_d = (bcd_q == 16'h9999);
`ifdef CONTADOR_BCD_DOWN_EN
      if (dir) begin
        bcd_d = bcd_dec(bcd_q);
        ovf_d = (bcd_q == 16'h0000);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      tick_q   <= 1'b0;
      s_meta_q <= 1'b0;
      s_sync_q <= 1'b0;
      s_prev_q <= 1'b0;
      step_p_q <= 1'b0;
      bcd_q    <= '0;
      upd_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      s_meta_q <= step;
      s_sync_q <= s_meta_q;
      s_prev_q <= s_sync_q;
      step_p_q <= s_sync_q & ~s_prev_q;
      bcd_q    <= bcd_d;
      upd_q    <= upd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign upd  = upd_q;
  assign ovf  = ovf_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_contador_bcd.sv
// Directed bench for contador_bcd at PRESCALE=4; outputs sampled 1ns after each rising edge.
module tb_contador_bcd;

  logic        clk = 1'b0;
  logic        rst, en, clr, step, dir;
  logic [15:0] bcd;
  logic        upd, ovf, tick;
  int          total = 0;
  int          bad   = 0;

  contador_bcd #(.PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .step(step), .dir(dir),
    .bcd(bcd), .upd(upd), .ovf(ovf), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; step = 1'b0; dir = 1'b0;
    repeat (3) cyc();
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_upd", 16'(upd), 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    chk("rst_tick", 16'(tick), 16'h0);

    // free run: tick after the 4th edge, new bcd one cycle later
    rst = 1'b0; en = 1'b1;
    repeat (3) cyc();
    chk("run_tick_early", 16'(tick), 16'h0);
    cyc();
    chk("run_tick", 16'(tick), 16'h1);
    chk("run_bcd_before", bcd, 16'h0000);
    cyc();
    chk("run_bcd1", bcd, 16'h0001);
    chk("run_upd1", 16'(upd), 16'h1);
    chk("run_tick_low", 16'(tick), 16'h0);
    cyc();
    chk("run_upd_low", 16'(upd), 16'h0);
    repeat (31) cyc();
    chk("run_bcd9", bcd, 16'h0009);
    repeat (4) cyc();
    chk("carry_bcd", bcd, 16'h0010);
    chk("carry_upd", 16'(upd), 16'h1);
    repeat (108) cyc();
    chk("pre_rst_bcd", bcd, 16'h0037);

    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("async_rst_bcd", bcd, 16'h0000);
    chk("async_rst_upd", 16'(upd), 16'h0);
    chk("async_rst_ovf", 16'(ovf), 16'h0);
    chk("async_rst_tick", 16'(tick), 16'h0);
    cyc();
    #2 rst = 1'b0;
    repeat (5) cyc();
    chk("resume_bcd", bcd, 16'h0001);
    chk("resume_upd", 16'(upd), 16'h1);

    // wrap 9999 -> 0000
    repeat (4 * 9998) cyc();
    chk("pre_wrap_bcd", bcd, 16'h9999);
    chk("pre_wrap_ovf", 16'(ovf), 16'h0);
    repeat (4) cyc();
    chk("wrap_bcd", bcd, 16'h0000);
    chk("wrap_upd", 16'(upd), 16'h1);
    chk("wrap_ovf", 16'(ovf), 16'h1);
    cyc();
    chk("wrap_ovf_pulse", 16'(ovf), 16'h0);
    chk("wrap_upd_pulse", 16'(upd), 16'h0);

    // held step button with the prescaler stopped
    en = 1'b0; step = 1'b1;
    cyc();
    chk("step_k0", bcd, 16'h0000);
    cyc();
    cyc();
    chk("step_k2", bcd, 16'h0000);
    cyc();
    chk("step_k3_bcd", bcd, 16'h0001);
    chk("step_k3_upd", 16'(upd), 16'h1);
    repeat (6) cyc();
    chk("step_hold_bcd", bcd, 16'h0001);
    chk("step_hold_upd", 16'(upd), 16'h0);
    step = 1'b0;
    repeat (3) cyc();

    // step pulse coincident with tick (prescaler held at 2)
    step = 1'b1;
    cyc();
    en = 1'b1;
    cyc();
    cyc();
    chk("coin_tick", 16'(tick), 16'h1);
    cyc();
    chk("coin_bcd", bcd, 16'h0002);
    chk("coin_upd", 16'(upd), 16'h1);
    cyc();
    chk("coin_single", bcd, 16'h0002);
    step = 1'b0;
    repeat (483) cyc();
    chk("pre_clr_bcd", bcd, 16'h0123);

    // clear while a tick is pending
    repeat (3) cyc();
    chk("clr_ev_tick", 16'(tick), 16'h1);
    clr = 1'b1;
    cyc();
    chk("clr_bcd", bcd, 16'h0000);
    chk("clr_upd", 16'(upd), 16'h1);
    chk("clr_ovf", 16'(ovf), 16'h0);
    cyc();
    chk("clr_again_upd", 16'(upd), 16'h0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("clr_hold_tick", 16'(tick), 16'h0);
      chk("clr_hold_bcd", bcd, 16'h0000);
    end
    clr = 1'b0; dir = 1'b1;
    repeat (5) cyc();
`ifdef CONTADOR_BCD_DOWN_EN
    chk("down_wrap_bcd", bcd, 16'h9999);
    chk("down_wrap_upd", 16'(upd), 16'h1);
    chk("down_wrap_ovf", 16'(ovf), 16'h1);
    clr = 1'b1;
    cyc();
    chk("down_clr_bcd", bcd, 16'h0000);
    chk("down_clr_upd", 16'(upd), 16'h1);
    clr = 1'b0; dir = 1'b0;
    repeat (401) cyc();
    chk("down_pre_bcd", bcd, 16'h0100);
    dir = 1'b1;
    repeat (4) cyc();
    chk("down_borrow_bcd", bcd, 16'h0099);
    chk("down_borrow_upd", 16'(upd), 16'h1);
    chk("down_borrow_ovf", 16'(ovf), 16'h0);
`else
    chk("dir_ignored_bcd", bcd, 16'h0001);
    chk("dir_ignored_upd", 16'(upd), 16'h1);
    chk("dir_ignored_ovf", 16'(ovf), 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
